// File: rtl/clock_pkg.sv
// Shared types and timing defaults for the clock-setting front end.
// Holds the key conditioner state encoding and its 50 MHz default timings.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    REL_DB
  } kc_state_t;

  localparam int CLK_HZ               = 50_000_000;
  localparam int KC_DEBOUNCE_DEF      = 1_000_000;   // 20 ms
  localparam int KC_REPEAT_DELAY_DEF  = 25_000_000;  // 0.5 s
  localparam int KC_REPEAT_PERIOD_DEF = 10_000_000;  // 0.2 s

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so the idle level of the input is seen during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/key_conditioner.sv
// Turns one raw active-low push-button into debounced press/release pulses
// with optional auto-repeat while held.
//
// state    | meaning
// IDLE     | released, waiting for a press sample
// PRESS_DB | press seen, counting stable pressed samples
// HELD     | press accepted, counting towards the first repeat
// REPEAT   | auto-repeating every REPEAT_PERIOD cycles
// REL_DB   | release seen, counting stable released samples
module key_conditioner
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = KC_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = KC_REPEAT_PERIOD_DEF,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse,
  output logic key_level,
  output logic release_pulse
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_P);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  logic sync_key_n;
  logic pressed;

  kc_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          press_q, press_d;
  logic          level_q, level_d;
  logic          rel_q, rel_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (key_n),
    .q_o   (sync_key_n)
  );

  assign pressed = ~sync_key_n;

  // Saturating increment: the count must never wrap back into a compare window.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      press_q <= 1'b0;
      level_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      level_q <= level_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    level_d = level_q;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_DB;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          press_d = 1'b1;
          level_d = 1'b1;
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = REL_DB;
          cnt_d   = CNT_ONE;
        end else if ((REPEAT_EN != 0) && (cnt_q == DLY_LAST)) begin
          press_d = 1'b1;
          state_d = REPEAT;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPEAT: begin
        if (!pressed) begin
          state_d = REL_DB;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == PER_LAST) begin
          press_d = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REL_DB: begin
        // A bounce back to pressed keeps the key held and restarts the repeat delay.
        if (pressed) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          rel_d   = 1'b1;
          level_d = 1'b0;
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign press_pulse   = press_q;
  assign key_level     = level_q;
  assign release_pulse = rel_q;

endmodule
